// File: rtl/display_scan.sv
// Scans four active-low digit patterns onto a shared 4-digit display with per-slot blanking and adjust-mode blink; DISPLAY_SCAN_COLON_EN lights digit 2's dp as a colon.
// Latency: one clk from internal state to seg/an pins. Free-running with no backpressure; inputs are sampled as plain levels.
module display_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 2000,
    parameter int CNT_W     = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_min_top,
    input  logic [7:0] seg_min_bot,
    input  logic [7:0] seg_sec_top,
    input  logic [7:0] seg_sec_bot,
    input  logic       adj,
    input  logic       sel,
    input  logic       blink,
    output logic [7:0] seg,
    output logic [3:0] an
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       snap_q, snap_d;
    logic             blink_q, blink_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic             slot_end;
    logic             pair_hit;
    logic             blank;
    logic [7:0]       pattern;

    always_comb begin
        pattern = seg_sec_bot;
        case (idx_q)
            2'd0: pattern = seg_sec_bot;
            2'd1: pattern = seg_sec_top;
            2'd2: pattern = seg_min_bot;
            2'd3: pattern = seg_min_top;
            default: pattern = seg_sec_bot;
        endcase
    end

    // Pattern is frozen at slot start so mid-slot input changes never tear a digit.
    always_comb begin
        slot_end = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        snap_d   = (cnt_q == '0) ? pattern : snap_q;
        blink_d  = blink;
    end

    always_comb begin
        pair_hit = sel ? ~idx_q[1] : idx_q[1];
        blank    = (cnt_q < CNT_W'(BLANK_CYC)) | (adj & blink_q & pair_hit);
        an_d     = 4'b1111;
        seg_d    = 8'hFF;
        if (!blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = snap_q;
`ifdef DISPLAY_SCAN_COLON_EN
            if (idx_q == 2'd2) begin
                seg_d[7] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            snap_q  <= 8'hFF;
            blink_q <= 1'b0;
            seg_q   <= 8'hFF;
            an_q    <= 4'b1111;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            blink_q <= blink_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with a cycle-position reference model and literal spot checks.
module tb_display_scan;
    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg_min_top = 8'hB0;
    logic [7:0] seg_min_bot = 8'hA4;
    logic [7:0] seg_sec_top = 8'hF9;
    logic [7:0] seg_sec_bot = 8'hC0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       blink = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;

    int total = 0;
    int bad   = 0;

    display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .seg_min_top(seg_min_top), .seg_min_bot(seg_min_bot),
        .seg_sec_top(seg_sec_top), .seg_sec_bot(seg_sec_bot),
        .adj(adj), .sel(sel), .blink(blink),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pos counts clock edges since reset release; slot and digit come from division.
    int         pos = 0;
    logic [7:0] snap_m = 8'hFF;
    logic       blink_m = 1'b0;
    logic [7:0] exp_seg = 8'hFF;
    logic [3:0] exp_an = 4'hF;
    bit         model_vld = 0;

    function automatic logic [7:0] pick(input int d);
        case (d)
            0: return seg_sec_bot;
            1: return seg_sec_top;
            2: return seg_min_bot;
            default: return seg_min_top;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pos = 0; snap_m = 8'hFF; blink_m = 1'b0;
            exp_seg = 8'hFF; exp_an = 4'hF; model_vld = 1;
        end else begin
            int  c;
            int  d;
            bit  hide;
            c = pos % SD;
            d = (pos / SD) % 4;
            if (c == 0) snap_m = pick(d);
            hide = (c < BC) || (adj && blink_m && (sel ? (d < 2) : (d >= 2)));
            if (hide) begin
                exp_an = 4'hF; exp_seg = 8'hFF;
            end else begin
                exp_an = 4'hF;
                exp_an[d] = 1'b0;
                exp_seg = snap_m;
`ifdef DISPLAY_SCAN_COLON_EN
                if (d == 2) exp_seg[7] = 1'b0;
`endif
            end
            blink_m = blink;
            pos++;
        end
    end

    always @(negedge clk) begin
        if (model_vld) begin
            check("an_model", 32'(an), 32'(exp_an));
            check("seg_model", 32'(seg), 32'(exp_seg));
            check("an_onehot0", 32'($onehot0(~an)), 32'd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_digit2(input string name);
        int k;
        k = 0;
        while (an !== 4'b1011 && k < 80) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k < 80), 32'd1);
    endtask

    initial begin
        int lo;
        cyc(3);
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'hFF);
        rst = 1'b0;
        cyc(1);  check("c1_an", 32'(an), 32'hF);
        cyc(1);  check("c2_an", 32'(an), 32'hF);
        cyc(1);  check("c3_an", 32'(an), 32'hE); check("c3_seg", 32'(seg), 32'hC0);
        cyc(5);  check("c8_an", 32'(an), 32'hE); check("c8_seg", 32'(seg), 32'hC0);
        cyc(1);  check("c9_an", 32'(an), 32'hF);
        cyc(2);  check("c11_an", 32'(an), 32'hD); check("c11_seg", 32'(seg), 32'hF9);
        cyc(24); check("c35_an", 32'(an), 32'hE); check("c35_seg", 32'(seg), 32'hC0);
        cyc(1);  seg_sec_bot = 8'h99;
        cyc(4);  check("c40_hold_an", 32'(an), 32'hE); check("c40_hold_seg", 32'(seg), 32'hC0);
        cyc(27); check("c67_new_an", 32'(an), 32'hE); check("c67_new_seg", 32'(seg), 32'h99);

        adj = 1'b1; sel = 1'b0; blink = 1'b1;
        cyc(2);
        lo = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            check("min_blank", 32'(an[3:2]), 32'd3);
            if (!an[0]) lo++;
        end
        check("min_blank_d0_cnt", 32'(lo), 32'd6);

        sel = 1'b1;
        cyc(2);
        lo = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            check("sec_blank", 32'(an[1:0]), 32'd3);
            if (!an[2]) lo++;
        end
        check("sec_blank_d2_cnt", 32'(lo), 32'd6);

        for (int i = 0; i < 8; i++) begin
            blink = ~blink;
            cyc(16);
        end

        adj = 1'b0; blink = 1'b0;
        wait_digit2("wait_d2_a");
        cyc(1);
        rst = 1'b1;
        cyc(1);  check("rst_mid_an", 32'(an), 32'hF); check("rst_mid_seg", 32'(seg), 32'hFF);
        cyc(1);
        rst = 1'b0;
        cyc(2);  check("rel_c2_an", 32'(an), 32'hF);
        cyc(1);  check("rel_c3_an", 32'(an), 32'hE); check("rel_c3_seg", 32'(seg), 32'h99);

        wait_digit2("wait_d2_b");
`ifdef DISPLAY_SCAN_COLON_EN
        check("colon_seg", 32'(seg), 32'h24);
`else
        check("colon_seg", 32'(seg), 32'hA4);
`endif
        cyc(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
